// File: rtl/instr_decode_ctrl_if.sv
// Fetch handshake and data-memory strobe bus between the decode controller
// (master) and the instruction/data memory side (slave).
interface instr_decode_ctrl_if;
  logic       inst_valid;
  logic [7:0] inst_data;
  logic       inst_ready;
  logic [7:0] pc;
  logic       mem_read;
  logic       mem_write;
  logic       dmem_done;

  modport master (
    input  inst_valid, inst_data, dmem_done,
    output inst_ready, pc, mem_read, mem_write
  );

  modport slave (
    output inst_valid, inst_data, dmem_done,
    input  inst_ready, pc, mem_read, mem_write
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/control FSM for the 8-bit, 4-register datapath.
// IR[7:6]=op, [5:4]=rs, [3:2]=rt, [1:0]=rd/imm; ops add, lw, sw, j.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | stopped at an instruction boundary, waiting for run
// S_FETCH  | inst_ready high, waiting for inst_valid
// S_DECODE | fields visible from IR, signext settles (1 cycle)
// S_EXEC   | ALU op, memory strobe until dmem_done, or jump resolution
// S_WB     | single reg_write cycle
// S_HALT   | jump-to-self or memory timeout; only Clear leaves
module instr_decode_ctrl #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                       Clk,
  input  logic                       Clear,
  input  logic                       run,
  instr_decode_ctrl_if.master        bus,
  output logic [1:0]                 rs,
  output logic [1:0]                 rt,
  output logic [1:0]                 rd,
  output logic [1:0]                 imm,
  output logic                       alu_src,
  output logic                       mem_to_reg,
  output logic                       reg_write,
  output logic [7:0]                 instr_count,
  output logic                       halted,
  output logic                       mem_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Timeout fires on the EXEC cycle that would bring the count to MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [7:0] ir;
  logic [7:0] pc_q;
  logic [7:0] wait_cnt;
  logic       inst_ready_q;
  logic       mem_read_q;
  logic       mem_write_q;

  logic [1:0] op;
  logic [7:0] jmp_target;
  logic [7:0] pc_prev;

  assign op         = ir[7:6];
  assign jmp_target = {pc_q[7:6], ir[5:0]};
  assign pc_prev    = pc_q - 8'd1;

  // Fields come straight from the IR register, so they change only on an
  // accepted fetch and are already valid in DECODE.
  assign rs  = ir[5:4];
  assign rt  = ir[3:2];
  assign rd  = ir[1:0];
  assign imm = ir[1:0];

  assign bus.inst_ready = inst_ready_q;
  assign bus.pc         = pc_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state        <= S_IDLE;
      ir           <= 8'h00;
      pc_q         <= RESET_PC;
      wait_cnt     <= 8'h00;
      inst_ready_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src      <= 1'b0;
      mem_to_reg   <= 1'b0;
      reg_write    <= 1'b0;
      instr_count  <= 8'h00;
      halted       <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state        <= S_FETCH;
            inst_ready_q <= 1'b1;
          end
        end

        S_FETCH: begin
          if (bus.inst_valid) begin
            ir           <= bus.inst_data;
            pc_q         <= pc_q + 8'd1;
            inst_ready_q <= 1'b0;
            state        <= S_DECODE;
          end
        end

        S_DECODE: begin
          state       <= S_EXEC;
          wait_cnt    <= 8'h00;
          alu_src     <= (op == OP_LW) || (op == OP_SW);
          mem_read_q  <= (op == OP_LW);
          mem_write_q <= (op == OP_SW);
        end

        S_EXEC: begin
          case (op)
            OP_ADD: begin
              state      <= S_WB;
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b0;
            end

            OP_LW, OP_SW: begin
              if (bus.dmem_done) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (op == OP_LW) begin
                  state      <= S_WB;
                  reg_write  <= 1'b1;
                  mem_to_reg <= 1'b1;
                end else begin
                  instr_count  <= instr_count + 8'd1;
                  alu_src      <= 1'b0;
                  state        <= run ? S_FETCH : S_IDLE;
                  inst_ready_q <= run;
                end
              end else begin
                wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt == WAIT_LAST) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  mem_err     <= 1'b1;
                  halted      <= 1'b1;
                  state       <= S_HALT;
                end
              end
            end

            OP_J: begin
              instr_count <= instr_count + 8'd1;
              // pc already points past the jump, so pc-1 is the jump itself.
              if (jmp_target == pc_prev) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                pc_q         <= jmp_target;
                state        <= run ? S_FETCH : S_IDLE;
                inst_ready_q <= run;
              end
            end

            default: state <= S_HALT;
          endcase
        end

        S_WB: begin
          reg_write    <= 1'b0;
          mem_to_reg   <= 1'b0;
          alu_src      <= 1'b0;
          instr_count  <= instr_count + 8'd1;
          state        <= run ? S_FETCH : S_IDLE;
          inst_ready_q <= run;
        end

        S_HALT: begin
          halted       <= 1'b1;
          inst_ready_q <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl: write-back events are checked against
// a scoreboard queue filled when each instruction is presented.
module tb_instr_decode_ctrl;

  logic       clk;
  logic       Clear;
  logic       run;
  logic [1:0] rs, rt, rd, imm;
  logic       alu_src, mem_to_reg, reg_write;
  logic [7:0] instr_count;
  logic       halted, mem_err;

  instr_decode_ctrl_if ifc ();

  instr_decode_ctrl #(.RESET_PC(8'h00), .MAX_WAIT(15)) dut (
    .Clk         (clk),
    .Clear       (Clear),
    .run         (run),
    .bus         (ifc),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .instr_count (instr_count),
    .halted      (halted),
    .mem_err     (mem_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] wb_q[$];
  logic [7:0] exp_pc;
  logic [7:0] exp_count;
  logic       exp_halt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {rs, rt, rd, mem_to_reg} for every reg_write pulse.
  always @(negedge clk) begin
    if (!Clear && reg_write) begin
      if (wb_q.size() == 0) check("wb_unexpected", 32'(reg_write), 32'd0);
      else check("wb_fields", 32'({rs, rt, rd, mem_to_reg}), 32'(wb_q.pop_front()));
    end
  end

  // Presents one non-memory instruction, follows it to the next boundary.
  task automatic run_instr(input logic [7:0] instr);
    int n;
    logic [7:0] tgt;
    n = 0;
    while (!ifc.inst_ready && n < 20) begin tick(); n++; end
    check("fetch_ready", 32'(ifc.inst_ready), 32'd1);
    ifc.inst_valid = 1'b1;
    ifc.inst_data  = instr;
    if (instr[7:6] == 2'b00) wb_q.push_back({instr[5:4], instr[3:2], instr[1:0], 1'b0});
    tick();
    ifc.inst_valid = 1'b0;
    exp_pc    = exp_pc + 8'd1;
    exp_count = exp_count + 8'd1;
    if (instr[7:6] == 2'b11) begin
      tgt = {exp_pc[7:6], instr[5:0]};
      if (tgt == exp_pc - 8'd1) exp_halt = 1'b1;
      else exp_pc = tgt;
    end
    n = 0;
    while (!(ifc.inst_ready || halted) && n < 20) begin tick(); n++; end
    check("pc_after", 32'(ifc.pc), 32'(exp_pc));
    check("count_after", 32'(instr_count), 32'(exp_count));
    check("halted_after", 32'(halted), 32'(exp_halt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int hi;
    Clear          = 1'b1;
    run            = 1'b0;
    ifc.inst_valid = 1'b0;
    ifc.inst_data  = 8'h00;
    ifc.dmem_done  = 1'b0;
    exp_pc         = 8'h00;
    exp_count      = 8'h00;
    exp_halt       = 1'b0;
    tick(); tick();
    Clear = 1'b0;

    // reset state
    check("rst_pc", 32'(ifc.pc), 32'h00);
    check("rst_outputs", 32'({ifc.inst_ready, ifc.mem_read, ifc.mem_write, alu_src,
                              mem_to_reg, reg_write, halted, mem_err}), 32'd0);
    check("rst_fields", 32'({rs, rt, rd, imm}), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);

    // add 1B with valid held high through the whole instruction
    run = 1'b1; ifc.inst_valid = 1'b1; ifc.inst_data = 8'h1B;
    wb_q.push_back({2'd1, 2'd2, 2'd3, 1'b0});
    tick();
    check("add_fetch_ready", 32'(ifc.inst_ready), 32'd1);
    tick();
    check("add_decode_pc", 32'(ifc.pc), 32'h01);
    check("add_decode_fields", 32'({rs, rt, rd}), 32'({2'd1, 2'd2, 2'd3}));
    check("add_decode_ready", 32'(ifc.inst_ready), 32'd0);
    tick();
    check("add_exec", 32'({alu_src, reg_write}), 32'd0);
    tick();
    check("add_wb", 32'({reg_write, mem_to_reg}), 32'b10);
    ifc.inst_valid = 1'b0;
    tick();
    check("add_wb_one_cycle", 32'(reg_write), 32'd0);
    check("add_count", 32'(instr_count), 32'd1);
    check("add_pc_held", 32'(ifc.pc), 32'h01);
    check("add_back_fetch", 32'(ifc.inst_ready), 32'd1);

    // lw 5E, dmem_done in third EXEC cycle
    ifc.inst_valid = 1'b1; ifc.inst_data = 8'h5E;
    wb_q.push_back({2'd1, 2'd3, 2'd2, 1'b1});
    tick();
    ifc.inst_valid = 1'b0;
    check("lw_decode_pc", 32'(ifc.pc), 32'h02);
    check("lw_imm", 32'(imm), 32'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_read", 32'({ifc.mem_read, alu_src}), 32'b11);
      if (i == 2) ifc.dmem_done = 1'b1;
      tick();
    end
    ifc.dmem_done = 1'b0;
    check("lw_strobe_drop", 32'(ifc.mem_read), 32'd0);
    check("lw_wb", 32'({reg_write, mem_to_reg}), 32'b11);
    tick();
    check("lw_count", 32'(instr_count), 32'd2);

    // add 06, run dropped during WB
    ifc.inst_valid = 1'b1; ifc.inst_data = 8'h06;
    wb_q.push_back({2'd0, 2'd1, 2'd2, 1'b0});
    tick();
    ifc.inst_valid = 1'b0;
    tick(); tick();
    check("stop_wb", 32'(reg_write), 32'd1);
    run = 1'b0;
    tick();
    check("stop_idle", 32'({ifc.inst_ready, instr_count, ifc.pc}), 32'({1'b0, 8'd3, 8'h03}));
    tick(); tick(); tick();
    check("stop_stays", 32'(ifc.inst_ready), 32'd0);
    run = 1'b1;
    tick();
    check("resume_fetch", 32'({ifc.inst_ready, ifc.pc}), 32'({1'b1, 8'h03}));

    // Clear during lw EXEC
    ifc.inst_valid = 1'b1; ifc.inst_data = 8'h5E;
    tick();
    ifc.inst_valid = 1'b0;
    tick();
    check("clr_exec_read", 32'(ifc.mem_read), 32'd1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clr_pc", 32'(ifc.pc), 32'h00);
    check("clr_outputs", 32'({ifc.inst_ready, ifc.mem_read, ifc.mem_write, alu_src,
                              reg_write, halted, mem_err}), 32'd0);
    check("clr_count", 32'(instr_count), 32'd0);
    exp_pc = 8'h00; exp_count = 8'h00;

    // sw 9D with dmem_done from DECODE on: ignored there, finishes in EXEC cycle 1
    tick();
    check("sw_fetch_ready", 32'(ifc.inst_ready), 32'd1);
    ifc.inst_valid = 1'b1; ifc.inst_data = 8'h9D;
    tick();
    ifc.inst_valid = 1'b0;
    ifc.dmem_done  = 1'b1;
    tick();
    check("sw_exec", 32'({ifc.mem_write, ifc.mem_read, alu_src}), 32'b101);
    tick();
    ifc.dmem_done = 1'b0;
    check("sw_done", 32'({ifc.mem_write, reg_write, instr_count, ifc.pc}),
          32'({1'b0, 1'b0, 8'd1, 8'h01}));
    exp_pc = 8'h01; exp_count = 8'd1;

    // jumps: climb to 8'h42, j C7, then to 8'hFF and wrap
    run_instr(8'hFF);
    run_instr(8'h00);
    run_instr(8'hC2);
    check("j_reach_42", 32'(ifc.pc), 32'h42);
    run_instr(8'hC7);
    check("j_c7_target", 32'(ifc.pc), 32'h47);
    run_instr(8'hFF);
    run_instr(8'h00);
    run_instr(8'hFF);
    run_instr(8'h00);
    run_instr(8'hFF);
    check("pc_at_ff", 32'(ifc.pc), 32'hFF);
    run_instr(8'h00);
    check("pc_wrap", 32'(ifc.pc), 32'h00);

    // sw timeout
    ifc.inst_valid = 1'b1; ifc.inst_data = 8'h9D;
    tick();
    ifc.inst_valid = 1'b0;
    tick();
    hi = 0;
    while (ifc.mem_write && hi < 40) begin hi++; tick(); end
    check("sw_timeout_cycles", 32'(hi), 32'd15);
    check("sw_timeout_flags", 32'({mem_err, halted, ifc.inst_ready}), 32'b110);
    check("sw_timeout_count", 32'(instr_count), 32'(exp_count));
    ifc.inst_valid = 1'b1; ifc.inst_data = 8'h00;
    tick(); tick(); tick();
    ifc.inst_valid = 1'b0;
    check("halt_holds", 32'({halted, ifc.inst_ready, ifc.pc}), 32'({1'b1, 1'b0, 8'h01}));

    // Clear leaves HALT; instr_count wraps on the 256th retire
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("halt_cleared", 32'({halted, mem_err}), 32'd0);
    exp_pc = 8'h00; exp_count = 8'h00; exp_halt = 1'b0;
    for (int i = 0; i < 256; i++) begin
      run_instr(8'h00);
      if (i == 254) check("count_ff", 32'(instr_count), 32'hFF);
    end
    check("count_wrap", 32'(instr_count), 32'h00);

    // jump to self from 8'h42 halts
    run_instr(8'hFF);
    run_instr(8'h00);
    run_instr(8'hC2);
    run_instr(8'hC2);
    check("jself_state", 32'({halted, ifc.inst_ready, mem_err, ifc.pc}),
          32'({1'b1, 1'b0, 1'b0, 8'h43}));
    tick(); tick();
    check("jself_holds", 32'({halted, ifc.pc}), 32'({1'b1, 8'h43}));

    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
